// File: rtl/umai_pkg.sv
// ---------------------------------------------------------------------------
// umai_pkg
// Shared definitions for the UMAI lane datapath (upsize and downsize paths).
//   UMAI_WORD_W  : width of one lane word
//   UMAI_LANES   : lanes per narrow interface / words per memory line
//   UMAI_LINE_W  : width of one full memory line
//   umai_word_t  : one lane word
// ---------------------------------------------------------------------------
package umai_pkg;

  localparam int UMAI_WORD_W = 64;
  localparam int UMAI_LANES  = 8;
  localparam int UMAI_LINE_W = UMAI_WORD_W * UMAI_LANES;

  typedef logic [UMAI_WORD_W-1:0] umai_word_t;

endpackage

// File: rtl/umai_lane_rotator.sv
// ---------------------------------------------------------------------------
// umai_lane_rotator
// Combinational barrel mapping of a burst of consecutive words onto output
// lanes. Burst word i (0 <= i <= size_i) lands on lane (i + offset_i) mod
// NUM_LANES. Lanes outside the burst, or every lane when en_i is low, drive
// zero data and a cleared valid bit.
//   en_i       : burst is being delivered this cycle
//   offset_i   : lane of burst word 0
//   size_i     : burst length minus one
//   words_i    : burst words in burst order (word 0 first)
//   valid_o    : per-lane valid mask
//   data_o     : per-lane data, zero where not valid
// ---------------------------------------------------------------------------
module umai_lane_rotator
  import umai_pkg::*;
#(
  parameter int WORD_W    = UMAI_WORD_W,
  parameter int NUM_LANES = UMAI_LANES,
  localparam int LW       = $clog2(NUM_LANES)
) (
  input  logic              en_i,
  input  logic [LW-1:0]     offset_i,
  input  logic [LW-1:0]     size_i,
  input  logic [WORD_W-1:0] words_i [NUM_LANES-1:0],
  output logic              valid_o [NUM_LANES-1:0],
  output logic [WORD_W-1:0] data_o  [NUM_LANES-1:0]
);

  // Each lane works out which burst word it would carry (its distance back
  // to the offset lane, modulo the lane count) and keeps it only if that
  // word is inside the burst.
  always_comb begin
    logic [LW-1:0] rel;
    logic          sel;
    for (int l = 0; l < NUM_LANES; l++) begin
      rel        = LW'(l) - offset_i;
      sel        = en_i && (rel <= size_i);
      valid_o[l] = sel;
      data_o[l]  = sel ? words_i[rel] : '0;
    end
  end

endmodule

// File: rtl/umai_downsize_buffer.sv
// ---------------------------------------------------------------------------
// umai_downsize_buffer
// Width-downsizing buffer: accepts full lines of NUM_LANES words and releases
// them as 1..NUM_LANES word bursts placed at a caller-chosen lane offset.
// Storage is a two-line ping-pong buffer with a word-granular read pointer
// that walks the concatenation {line1, line0} and wraps modulo 2*NUM_LANES.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_wvalid       : line write request        o_wready : a full line fits
//   i_wdata        : line, word k at [k*WORD_W +: WORD_W]
//   i_rvalid       : burst read request        o_rready : burst words held
//   i_roffset      : lane of first burst word  i_rsize  : burst length - 1
//   o_rdata_valid  : per-lane delivered flag   o_rdata  : per-lane word
//   o_level        : number of valid words held
// ---------------------------------------------------------------------------
module umai_downsize_buffer
  import umai_pkg::*;
#(
  parameter int WORD_W    = UMAI_WORD_W,
  parameter int NUM_LANES = UMAI_LANES,
  localparam int LINE_W   = WORD_W * NUM_LANES,
  localparam int LW       = $clog2(NUM_LANES),
  localparam int PW       = LW + 1,
  localparam int CW       = LW + 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wvalid,
  output logic              o_wready,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic              i_rvalid,
  output logic              o_rready,
  input  logic [LW-1:0]     i_roffset,
  input  logic [LW-1:0]     i_rsize,
  output logic              o_rdata_valid [NUM_LANES-1:0],
  output logic [WORD_W-1:0] o_rdata       [NUM_LANES-1:0],
  output logic [CW-1:0]     o_level
);

  logic [LINE_W-1:0] buf_q [2];
  logic              wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q,  cnt_d;

  logic              do_write, do_read;
  logic [CW-1:0]     burst_len;
  logic [CW-1:0]     add_w, sub_w;
  logic [WORD_W-1:0] burst_words [NUM_LANES-1:0];

  // Readiness looks only at registered state, so words or space produced in
  // this cycle never feed the opposite side combinationally.
  assign burst_len = {{(CW-LW){1'b0}}, i_rsize} + CW'(1);
  assign o_wready  = (cnt_q <= CW'(NUM_LANES));
  assign o_rready  = (cnt_q >= burst_len);
  assign do_write  = i_wvalid && o_wready;
  assign do_read   = i_rvalid && o_rready;
  assign o_level   = cnt_q;

  // Gather the burst in order starting at the read pointer. The index wraps
  // across both lines, which is how a burst straddles the ping-pong boundary.
  always_comb begin
    logic [PW-1:0] idx;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx            = rptr_q + PW'(i);
      burst_words[i] = buf_q[idx[PW-1]][int'(idx[LW-1:0])*WORD_W +: WORD_W];
    end
  end

  umai_lane_rotator #(
    .WORD_W    (WORD_W),
    .NUM_LANES (NUM_LANES)
  ) u_rot (
    .en_i     (do_read),
    .offset_i (i_roffset),
    .size_i   (i_rsize),
    .words_i  (burst_words),
    .valid_o  (o_rdata_valid),
    .data_o   (o_rdata)
  );

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    add_w  = '0;
    sub_w  = '0;
    if (do_write) begin
      wptr_d = ~wptr_q;
      add_w  = CW'(NUM_LANES);
    end
    if (do_read) begin
      rptr_d = rptr_q + {1'b0, i_rsize} + PW'(1);
      sub_w  = burst_len;
    end
    cnt_d = cnt_q + add_w - sub_w;
  end

  // A slot is written only while the count is at most one line, so the slot
  // under wptr_q never holds unread words when it is overwritten.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_write) begin
        buf_q[wptr_q] <= i_wdata;
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  a_cnt_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    cnt_q <= CW'(2 * NUM_LANES));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    do_read |-> ({1'b0, cnt_q} + {1'b0, add_w} >= {1'b0, sub_w}));

endmodule
